// File: rtl/ballot_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : ballot_input_unit
// Description : Front end of the 3-candidate voting machine. It synchronises
//               and debounces the candidate buttons, allows one vote per
//               officer-armed session, emits single-cycle vote pulses,
//               rejects multi-button presses, times out abandoned sessions
//               and locks out permanently once the poll is closed.
// Revision    : 1.0 - initial release
// ============================================================================
module ballot_input_unit #(
   parameter int N_CAND          = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_arm,
   input  logic [N_CAND-1:0] i_btn,
   input  logic              i_over,
   output logic [N_CAND-1:0] o_vote_pulse,
   output logic              o_ready,
   output logic              o_error,
   output logic              o_timeout,
   output logic [15:0]       o_ballots_cast
);

   // Run counters only need to reach DEBOUNCE_CYCLES-1; the timer only TIMEOUT_CYCLES-1.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_CAST    = 3'd2,
      S_REL     = 3'd3,
      S_ERR_REL = 3'd4,
      S_CLOSED  = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic              arm_s1, arm_s2, arm_d;
   logic              over_s1, over_s2;
   logic [N_CAND-1:0] btn_s1, btn_s2;
   logic [N_CAND-1:0] debounced;
   logic [TMR_W-1:0]  timer;
   logic              arm_rise, any_press, multi_press, one_hot, timeout_hit;
   logic              timer_clr, timer_inc;
   logic [N_CAND-1:0] vote_nxt;
   logic              error_nxt, timeout_nxt;

   // Two-flop synchronisers for all asynchronous inputs, plus arm edge history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_s1  <= 1'b0;
         arm_s2  <= 1'b0;
         arm_d   <= 1'b0;
         over_s1 <= 1'b0;
         over_s2 <= 1'b0;
         btn_s1  <= '0;
         btn_s2  <= '0;
      end else begin
         arm_s1  <= i_arm;
         arm_s2  <= arm_s1;
         arm_d   <= arm_s2;
         over_s1 <= i_over;
         over_s2 <= over_s1;
         btn_s1  <= i_btn;
         btn_s2  <= btn_s1;
      end
   end

   generate
      for (genvar k = 0; k < N_CAND; k++) begin : g_debounce
         logic [CNT_W-1:0] run_cnt;
         logic             deb_bit;

         // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               run_cnt <= '0;
               deb_bit <= 1'b0;
            end else if (btn_s2[k] == deb_bit) begin
               run_cnt <= '0;
            end else if (run_cnt == DB_LAST) begin
               run_cnt <= '0;
               deb_bit <= btn_s2[k];
            end else begin
               run_cnt <= run_cnt + CNT_W'(1);
            end
         end

         assign debounced[k] = deb_bit;
      end
   endgenerate

   assign arm_rise    = arm_s2 & ~arm_d;
   assign any_press   = |debounced;
   assign multi_press = any_press && ((debounced & (debounced - N_CAND'(1))) != '0);
   assign one_hot     = any_press && !multi_press;
   // The timer saturates at its last value, so a long ERR_REL stay still times out on return.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer >= TMR_LAST);

   // Session state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and pulse decode; poll close beats timeout beats error beats cast.
   always_comb begin
      state_nxt   = state;
      vote_nxt    = '0;
      error_nxt   = 1'b0;
      timeout_nxt = 1'b0;
      timer_clr   = 1'b0;
      timer_inc   = 1'b0;
      if (state != S_CLOSED && over_s2) begin
         state_nxt = S_CLOSED;
      end else begin
         case (state)
            S_IDLE: begin
               if (arm_rise && !any_press) begin
                  state_nxt = S_ARMED;
                  timer_clr = 1'b1;
               end
            end
            S_ARMED: begin
               timer_inc = 1'b1;
               if (timeout_hit) begin
                  state_nxt   = S_IDLE;
                  timeout_nxt = 1'b1;
               end else if (multi_press) begin
                  state_nxt = S_ERR_REL;
                  error_nxt = 1'b1;
               end else if (one_hot) begin
                  state_nxt = S_CAST;
                  vote_nxt  = debounced;
               end
            end
            S_CAST:    state_nxt = S_REL;
            S_REL:     if (!any_press) state_nxt = S_IDLE;
            S_ERR_REL: begin
               timer_inc = 1'b1;
               if (!any_press) state_nxt = S_ARMED;
            end
            S_CLOSED:  state_nxt = S_CLOSED;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // Session timer and registered output pulses / ballot counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer          <= '0;
         o_vote_pulse   <= '0;
         o_error        <= 1'b0;
         o_timeout      <= 1'b0;
         o_ballots_cast <= '0;
      end else begin
         if (timer_clr)                         timer <= '0;
         else if (timer_inc && timer < TMR_LAST) timer <= timer + TMR_W'(1);
         o_vote_pulse <= vote_nxt;
         o_error      <= error_nxt;
         o_timeout    <= timeout_nxt;
         if (vote_nxt != '0 && o_ballots_cast != 16'hFFFF)
            o_ballots_cast <= o_ballots_cast + 16'd1;
      end
   end

   assign o_ready = (state == S_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_ballot_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ballot_input_unit
// Description : Directed bench for ballot_input_unit with a scoreboard of
//               expected pulse events checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ballot_input_unit;

   localparam int N = 3;
   localparam int D = 4;
   localparam int T = 50;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_arm;
   logic         i_over;
   logic [N-1:0] i_btn;
   logic [N-1:0] o_vote_pulse;
   logic         o_ready;
   logic         o_error;
   logic         o_timeout;
   logic [15:0]  o_ballots_cast;

   ballot_input_unit #(
      .N_CAND          (N),
      .DEBOUNCE_CYCLES (D),
      .TIMEOUT_CYCLES  (T)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_arm          (i_arm),
      .i_btn          (i_btn),
      .i_over         (i_over),
      .o_vote_pulse   (o_vote_pulse),
      .o_ready        (o_ready),
      .o_error        (o_error),
      .o_timeout      (o_timeout),
      .o_ballots_cast (o_ballots_cast)
   );

   always #5 clk = ~clk;

   // Count of rising edges so far; events are expected at specific counts.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N-1:0] pulse;
      logic         err;
      logic         tmo;
      logic [15:0]  cast;
      int           at;     // expected edge count, -1 = any
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every pulse on the outputs must match the oldest expected event.
   logic [N-1:0] prev_pulse = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (o_vote_pulse != '0 || o_error || o_timeout)) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: pulse=%b error=%b timeout=%b, expected nothing (cycle %0d)",
                     o_vote_pulse, o_error, o_timeout, cyc);
         end else begin
            e = sb.pop_front();
            check("event_pulse",   32'(o_vote_pulse),   32'(e.pulse));
            check("event_error",   32'(o_error),        32'(e.err));
            check("event_timeout", 32'(o_timeout),      32'(e.tmo));
            check("event_cast",    32'(o_ballots_cast), 32'(e.cast));
            if (e.at >= 0) check("event_cycle", cyc, e.at);
         end
      end
      if (o_vote_pulse != '0) begin
         check("pulse_onehot", $countones(o_vote_pulse), 1);
         check("pulse_not_back_to_back", 32'(prev_pulse), 0);
      end
      prev_pulse = o_vote_pulse;
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise arm for 5 cycles; arm edge reaches the FSM 3 edges after it is raised.
   task automatic arm_session(input logic exp_ready, output int a);
      i_arm = 1'b1;
      a = cyc;
      wait_n(5);
      i_arm = 1'b0;
      check("ready_after_arm", 32'(o_ready), 32'(exp_ready));
   endtask

   task automatic check_idle_outputs(input string name, input logic [15:0] cast);
      check({name, "_pulse"},   32'(o_vote_pulse),   0);
      check({name, "_ready"},   32'(o_ready),        0);
      check({name, "_error"},   32'(o_error),        0);
      check({name, "_timeout"}, 32'(o_timeout),      0);
      check({name, "_cast"},    32'(o_ballots_cast), 32'(cast));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int c;
      rst = 1'b1; i_arm = 1'b0; i_btn = '0; i_over = 1'b0;
      wait_n(3);
      check_idle_outputs("reset", 16'd0);
      rst = 1'b0;
      wait_n(3);

      // 1: clean press of candidate 2, vote 2+D+1 edges after the press, held button gives nothing more
      arm_session(1'b1, a);
      c = cyc;
      sb.push_back('{3'b010, 1'b0, 1'b0, 16'd1, c + 3 + D});
      i_btn = 3'b010;
      wait_n(20);
      check("t1_cast", 32'(o_ballots_cast), 1);
      check("t1_ready_after_vote", 32'(o_ready), 0);
      i_btn = '0;
      wait_n(8);

      // 2: bouncing 3-cycle glitches on candidate 1, then stable high
      arm_session(1'b1, a);
      for (int i = 0; i < 3; i++) begin
         i_btn = 3'b001; wait_n(3);
         i_btn = 3'b000; wait_n(3);
      end
      c = cyc;
      sb.push_back('{3'b001, 1'b0, 1'b0, 16'd2, c + 3 + D});
      i_btn = 3'b001;
      wait_n(12);
      i_btn = '0;
      wait_n(8);

      // 3: double press raises error, session survives, then single press votes
      arm_session(1'b1, a);
      c = cyc;
      sb.push_back('{3'b000, 1'b1, 1'b0, 16'd2, c + 3 + D});
      i_btn = 3'b101;
      wait_n(8);
      check("t3_ready_in_err_rel", 32'(o_ready), 0);
      i_btn = '0;
      wait_n(8);
      check("t3_ready_rearmed", 32'(o_ready), 1);
      c = cyc;
      sb.push_back('{3'b100, 1'b0, 1'b0, 16'd3, c + 3 + D});
      i_btn = 3'b100;
      wait_n(10);
      check("t3_cast", 32'(o_ballots_cast), 3);
      i_btn = '0;
      wait_n(8);

      // 4: abandoned session times out exactly T edges after arming; late press ignored
      arm_session(1'b1, a);
      sb.push_back('{3'b000, 1'b0, 1'b1, 16'd3, a + 3 + T});
      wait_n(a + 2 + T - cyc);
      check("t4_ready_before_timeout", 32'(o_ready), 1);
      wait_n(2);
      check("t4_ready_after_timeout", 32'(o_ready), 0);
      i_btn = 3'b010;
      wait_n(12);
      check("t4_cast", 32'(o_ballots_cast), 3);
      i_btn = '0;
      wait_n(8);

      // 5: poll closed -> arm and press do nothing, count holds; reset clears it
      i_over = 1'b1;
      wait_n(4);
      arm_session(1'b0, a);
      i_btn = 3'b001;
      wait_n(12);
      check("t5_ready_closed", 32'(o_ready), 0);
      check("t5_cast_holds", 32'(o_ballots_cast), 3);
      i_btn = '0;
      wait_n(8);
      rst = 1'b1;
      wait_n(2);
      check_idle_outputs("t5_reset", 16'd0);
      i_over = 1'b0;
      rst = 1'b0;
      wait_n(3);

      // 6: arm while a button is held is ignored; reset mid-session gives no vote
      i_btn = 3'b010;
      wait_n(8);
      arm_session(1'b0, a);
      wait_n(5);
      check("t6_held_arm_ignored", 32'(o_ready), 0);
      i_btn = '0;
      wait_n(8);
      arm_session(1'b1, a);
      i_btn = 3'b001;
      wait_n(3);
      rst = 1'b1;
      wait_n(3);
      rst = 1'b0;
      wait_n(12);
      check_idle_outputs("t6_after_reset", 16'd0);
      i_btn = '0;
      wait_n(8);

      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
